btn_port: RTL
=============

BTN_PORT -- requirements
Module: btn_port

Interface
REQ-001 Parameter: WIDTH, 32, number of input pins and data bus width.
REQ-002 Parameter: DEB_DIV, 16, clk cycles between debounce sample ticks (>=2).
REQ-003 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  reset is synchronous and active-low (0 = reset, sampled on clk rising edge).
REQ-005 Port: pins  input  WIDTH  asynchronous button/switch levels from board or bench (PORTI/PORTJ source).
REQ-006 Port: cs  input  1  bus chip select.
REQ-007 Port: wen  input  1  bus write enable, qualified by cs.
REQ-008 Port: addr  input  2  register select.
REQ-009 Port: wdata  input  WIDTH  bus write data.
REQ-010 Port: rdata  output  WIDTH  bus read data.
REQ-011 Port: irq  output  1  interrupt request, level.

Function
REQ-012 Each pins bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A free-running tick counter SHALL assert a one-cycle tick every DEB_DIV clk cycles: counts 0..DEB_DIV-1, tick when count == DEB_DIV-1, then wraps to 0.
REQ-014 On each tick, each bit SHALL shift its synchronized value into a 3-bit sample history.
REQ-015 A bit's debounced value (STATE) SHALL take the new level in the cycle after a tick at which all 3 history samples are equal and differ from STATE; otherwise STATE holds.
REQ-016 A 0->1 change of STATE[n] SHALL set RISE[n]; a 1->0 change SHALL set FALL[n]; both flags are sticky.
REQ-017 Register map: addr 0 STATE (read-only, writes ignored); addr 1 RISE (write-1-to-clear); addr 2 FALL (write-1-to-clear); addr 3 MASK (read/write).
REQ-018 A write (cs=1, wen=1) SHALL take effect at the clk edge where it is sampled.
REQ-019 When a flag set and a W1C clear hit the same bit in the same cycle, set SHALL win (flag = 1).
REQ-020 rdata SHALL be combinational: selected register when cs=1 and wen=0, else all zeros.
REQ-021 irq SHALL be a registered OR over (RISE | FALL) & MASK, updating one cycle after any flag or MASK change.
REQ-022 Pin-to-STATE latency SHALL be 2 synchronizer cycles plus between 3 and 4 tick periods; pulses shorter than 3 consecutive samples SHALL never change STATE.
REQ-023 All WIDTH bits SHALL debounce independently using the shared tick.

Reset
REQ-024 While reset=0 at a clk edge: synchronizers, histories, STATE, RISE, FALL, MASK, tick counter and irq SHALL be cleared to 0.
REQ-025 Reset asserted mid-debounce SHALL discard partial history; no RISE/FALL SHALL be set by the reset itself or by the first post-reset tick.
REQ-026 After reset release, a pin held at 1 SHALL set STATE and RISE through normal debounce (reset value of STATE is 0).

Verification (DEB_DIV=4, WIDTH=32)
REQ-027 Reset held 3 cycles, pins=0x0000000E -> rdata 0 for all addrs during reset; STATE reads 0x0E within 2+4*4 cycles after release; RISE reads 0x0E; irq stays 0 (MASK=0).
REQ-028 pins bit0 glitches high for 5 clk cycles (< 2 ticks) -> STATE bit0 stays 0, RISE bit0 stays 0.
REQ-029 MASK write 0x1, bit0 rises and settles -> irq=1 one cycle after RISE[0]; write RISE=0x1 -> irq=0 next cycle; STATE unchanged.
REQ-030 pins 0x1B -> 0x15 -> RISE gains 0x04, FALL gains 0x0A; write FALL=0x08 -> FALL reads 0x02.
REQ-031 W1C to RISE[2] in the same cycle STATE[2] rises -> RISE[2] reads 1.
REQ-032 Write to addr 0 with 0xFFFFFFFF -> STATE unchanged; cs=0 -> rdata=0 regardless of addr.

Source files
------------

// File: rtl/btn_port.sv
// Button/switch input port: per-bit 2-flop sync, tick-based 3-sample debounce,
// sticky edge flags with W1C clear, interrupt mask and a small register window.
module btn_port #(
  parameter int WIDTH   = 32,
  parameter int DEB_DIV = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  input  logic             cs,
  input  logic             wen,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEB_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_DIV - 1);

  typedef enum logic [1:0] {
    ADDR_STATE = 2'd0,
    ADDR_RISE  = 2'd1,
    ADDR_FALL  = 2'd2,
    ADDR_MASK  = 2'd3
  } reg_sel_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick, tick_q;
  logic [WIDTH-1:0] hist0_q, hist1_q, hist2_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] stable, rise_clr, fall_clr;
  logic             irq_q, irq_d;
  logic             wr_en;
  reg_sel_e         sel;

  assign sel   = reg_sel_e'(addr);
  assign wr_en = cs & wen;
  assign tick  = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    rise_clr = '0;
    fall_clr = '0;
    mask_d   = mask_q;
    state_d  = state_q;

    // History is evaluated the cycle after the tick that shifted it in.
    stable = ~(hist0_q ^ hist1_q) & ~(hist1_q ^ hist2_q);
    if (tick_q) begin
      state_d = (stable & hist0_q) | (~stable & state_q);
    end

    if (wr_en) begin
      case (sel)
        ADDR_STATE: ;
        ADDR_RISE:  rise_clr = wdata;
        ADDR_FALL:  fall_clr = wdata;
        ADDR_MASK:  mask_d   = wdata;
        default:    ;
      endcase
    end

    // Set terms are OR-ed after the clear so a simultaneous edge wins.
    rise_d = (rise_q & ~rise_clr) | (state_d & ~state_q);
    fall_d = (fall_q & ~fall_clr) | (~state_d & state_q);
    irq_d  = |((rise_q | fall_q) & mask_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      hist0_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
      state_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      tick_q  <= tick;
      if (tick) begin
        hist2_q <= hist1_q;
        hist1_q <= hist0_q;
        hist0_q <= sync2_q;
      end
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (cs && !wen) begin
      case (sel)
        ADDR_STATE: rdata = state_q;
        ADDR_RISE:  rdata = rise_q;
        ADDR_FALL:  rdata = fall_q;
        ADDR_MASK:  rdata = mask_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule
